// File: rtl/tag_alloc_pkg.sv
// tag_alloc_pkg: state encoding and pool defaults shared by the controller and the free-tag FIFO
package tag_alloc_pkg;
  typedef enum logic [1:0] {CLR = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  localparam int DSIZE_DEF = 5;
  localparam int NUM_TAGS_DEF = 32;
endpackage

// File: rtl/tag_alloc_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] k;
  // scan from the farthest offset back to ptr so the nearest requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/tag_alloc_ctrl.sv
// tag_alloc_ctrl: fills the free-tag FIFO, arbitrates allocations, serialises releases; TAG_ALLOC_OCCUPANCY_EN adds free_cnt
module tag_alloc_ctrl
  import tag_alloc_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int NUM_REQ = 4,
  parameter int NUM_REL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       alloc_req,
  output logic [NUM_REQ-1:0]       alloc_gnt,
  output logic [DSIZE-1:0]         alloc_tag,
  input  logic [NUM_REL-1:0]       rel_valid,
  input  logic [NUM_REL*DSIZE-1:0] rel_tag,
  output logic [NUM_REL-1:0]       rel_ready,
  output logic                     busy,
  output logic [DSIZE-1:0]         fifo_wdata,
  output logic                     fifo_winc,
  output logic                     fifo_rinc,
  output logic                     fifo_rst_n,
  input  logic [DSIZE-1:0]         fifo_rdata,
  input  logic                     fifo_wfull,
  input  logic                     fifo_rempty
`ifdef TAG_ALLOC_OCCUPANCY_EN
  ,
  output logic [DSIZE:0]           free_cnt
`endif
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int RW = NUM_REL > 1 ? $clog2(NUM_REL) : 1;
  state_t state, state_nxt;
  logic [DSIZE-1:0] init_cnt;
  logic [PW-1:0] rr_ptr, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REL-1:0] slot_v;
  logic [DSIZE-1:0] slot_tag [NUM_REL];
  logic [RW-1:0] push_idx;
  logic rel_push;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req(alloc_req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  // lowest-indexed full slot owns the FIFO write port
  always_comb begin
    push_idx = '0;
    for (int j = NUM_REL - 1; j >= 0; j--) if (slot_v[j]) push_idx = RW'(j);
  end

  // next state and all outputs; flush overrides every grant and push
  always_comb begin
    state_nxt = state;
    alloc_gnt = '0;
    alloc_tag = '0;
    fifo_rinc = 1'b0;
    fifo_winc = 1'b0;
    fifo_wdata = '0;
    fifo_rst_n = 1'b1;
    busy = 1'b1;
    rel_ready = '0;
    case (state)
      CLR: begin
        fifo_rst_n = 1'b0;
        state_nxt = FILL;
      end
      FILL: begin
        fifo_winc = !fifo_wfull;
        fifo_wdata = init_cnt;
        if (fifo_winc && init_cnt == DSIZE'(NUM_TAGS - 1)) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b0;
        rel_ready = ~slot_v;
        alloc_gnt = fifo_rempty ? '0 : arb_gnt;
        fifo_rinc = |alloc_gnt;
        alloc_tag = fifo_rinc ? fifo_rdata : '0;
        fifo_winc = |slot_v && !fifo_wfull;
        fifo_wdata = fifo_winc ? slot_tag[push_idx] : '0;
      end
      default: state_nxt = CLR;
    endcase
    if (flush) begin
      state_nxt = CLR;
      alloc_gnt = '0;
      alloc_tag = '0;
      fifo_rinc = 1'b0;
      fifo_winc = 1'b0;
      fifo_wdata = '0;
    end
  end

  assign rel_push = fifo_winc && state == RUN;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLR;
    else state <= state_nxt;
  end

  // fill counter restarts from zero every time FILL is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_cnt <= '0;
    else if (state != FILL) init_cnt <= '0;
    else if (fifo_winc) init_cnt <= init_cnt + 1'b1;
  end

  // pointer moves just past each granted requester; survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else if (fifo_rinc) rr_ptr <= (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  end

  // one-entry release slots: capture when empty, clear when pushed, drop on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v <= '0;
      for (int j = 0; j < NUM_REL; j++) slot_tag[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_REL; j++) begin
        if (flush) slot_v[j] <= 1'b0;
        else if (rel_valid[j] && rel_ready[j]) begin
          slot_v[j] <= 1'b1;
          slot_tag[j] <= rel_tag[j*DSIZE +: DSIZE];
        end else if (rel_push && push_idx == RW'(j)) slot_v[j] <= 1'b0;
      end
    end
  end

`ifdef TAG_ALLOC_OCCUPANCY_EN
  localparam int CW = DSIZE + 1;
  logic [DSIZE:0] cnt_q, cnt_nxt;
  assign cnt_nxt = cnt_q + CW'(fifo_winc) - CW'(fifo_rinc);
  assign free_cnt = flush ? '0 : cnt_q;

  // number of tags currently held in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (flush || state == CLR) cnt_q <= '0;
    else cnt_q <= cnt_nxt;
  end

`ifndef SYNTHESIS
  // more free tags than exist means a tag was released twice
  always @(posedge clk) begin
    if (!rst && !flush && state != CLR && cnt_nxt > CW'(NUM_TAGS))
      $display("ERROR: tag_alloc_ctrl free_cnt overflow to %0d", cnt_nxt);
  end
`endif
`endif
endmodule
